// File: rtl/temporal_interval_pkg.sv
// Shared types for the temporal interval stage: one-hot FSM encoding and an activity helper.
package temporal_interval_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'b0001,
    StWaitMin = 4'b0010,
    StWaitMax = 4'b0100,
    StFinal   = 4'b1000
  } itv_state_t;

  function automatic logic is_active(itv_state_t s);
    return (s == StWaitMin) || (s == StWaitMax);
  endfunction

endpackage

// File: rtl/temporal_interval_duration_counter.sv
// Saturating elapsed-time counter: synchronous clear, counts enabled cycles, never wraps.
module temporal_interval_duration_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/temporal_interval.sv
// Temporal interval [d_min,d_max] ahead of a conditioned interaction point: releases the point
// after d_min, forces it at d_max, and forwards skip/kill.
module temporal_interval
  import temporal_interval_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             skip_in,
  input  logic             kill_in,
  input  logic             stop,
  input  logic             tick,
  input  logic             inf_max,
  input  logic [WIDTH-1:0] d_min,
  input  logic [WIDTH-1:0] d_max,
  output logic             start_p,
  output logic             event_e,
  output logic             skip_p,
  output logic             kill_p,
  output logic             urgent,
  output logic             active,
  output logic [WIDTH-1:0] elapsed
);

  itv_state_t       state_d, state_q;
  logic [WIDTH-1:0] dmin_d, dmin_q, dmax_d, dmax_q;
  logic             inf_d, inf_q, urgent_d, urgent_q;
  logic             start_p_d, start_p_q, event_e_d, event_e_q;
  logic             skip_p_d, skip_p_q, kill_p_d, kill_p_q;
  logic [WIDTH-1:0] count;

  // Counter sits at zero while idle, so arming always starts from 0.
  temporal_interval_duration_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == StIdle),
    .enable(tick && is_active(state_q)),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    dmin_d    = dmin_q;
    dmax_d    = dmax_q;
    inf_d     = inf_q;
    urgent_d  = urgent_q;
    start_p_d = 1'b0;
    event_e_d = 1'b0;
    skip_p_d  = 1'b0;
    kill_p_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (kill_in) begin
          state_d  = StFinal;
          kill_p_d = 1'b1;
        end else if (skip_in) begin
          state_d  = StFinal;
          skip_p_d = 1'b1;
        end else if (start) begin
          state_d  = StWaitMin;
          dmin_d   = d_min;
          dmax_d   = (d_max > d_min) ? d_max : d_min;
          inf_d    = inf_max;
          urgent_d = (d_min == d_max) && !inf_max;
        end
      end
      StWaitMin: begin
        if (kill_in) begin
          state_d  = StFinal;
          kill_p_d = 1'b1;
        end else if (count >= dmin_q) begin
          state_d   = StWaitMax;
          start_p_d = 1'b1;
        end
      end
      StWaitMax: begin
        if (kill_in) begin
          state_d  = StFinal;
          kill_p_d = 1'b1;
        end else if (stop) begin
          state_d = StFinal;
        end else if (!inf_q && (count >= dmax_q)) begin
          state_d   = StFinal;
          event_e_d = 1'b1;
        end
      end
      StFinal: ;
      default: state_d = StFinal;
    endcase
    if (state_d == StFinal) begin
      urgent_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      dmin_q    <= '0;
      dmax_q    <= '0;
      inf_q     <= 1'b0;
      urgent_q  <= 1'b0;
      start_p_q <= 1'b0;
      event_e_q <= 1'b0;
      skip_p_q  <= 1'b0;
      kill_p_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dmin_q    <= dmin_d;
      dmax_q    <= dmax_d;
      inf_q     <= inf_d;
      urgent_q  <= urgent_d;
      start_p_q <= start_p_d;
      event_e_q <= event_e_d;
      skip_p_q  <= skip_p_d;
      kill_p_q  <= kill_p_d;
    end
  end

  assign start_p = start_p_q;
  assign event_e = event_e_q;
  assign skip_p  = skip_p_q;
  assign kill_p  = kill_p_q;
  assign urgent  = urgent_q;
  assign active  = is_active(state_q);
  assign elapsed = count;

endmodule

// File: tb/tb_temporal_interval.sv
// Scoreboarded random bench for temporal_interval: a timeline model predicts pulses and levels.
module tb_temporal_interval;

  localparam int unsigned W = 4;
  localparam int L = 64;
  localparam int NRAND = 40;
  localparam int KStart = 0, KEvent = 1, KSkip = 2, KKill = 3;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  logic         clk, rst, start, skip_in, kill_in, stop, tick, inf_max;
  logic [W-1:0] d_min, d_max, elapsed;
  logic         start_p, event_e, skip_p, kill_p, urgent, active;

  temporal_interval #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .skip_in(skip_in),
    .kill_in(kill_in),
    .stop   (stop),
    .tick   (tick),
    .inf_max(inf_max),
    .d_min  (d_min),
    .d_max  (d_max),
    .start_p(start_p),
    .event_e(event_e),
    .skip_p (skip_p),
    .kill_p (kill_p),
    .urgent (urgent),
    .active (active),
    .elapsed(elapsed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   cur_k;
  bit   chk_en;
  int   n_chk, n_fail;
  int   exp_el[L];
  bit   exp_act[L];
  bit   exp_urg[L];
  logic [3:0] pv;
  exp_t e;

  function automatic string kname(int k);
    case (k)
      KStart:  return "start_p";
      KEvent:  return "event_e";
      KSkip:   return "skip_p";
      default: return "kill_p";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0d, required %0d", nm, cur_k, act, req);
    end
  endtask

  // Monitor: level checks every cycle, pulses popped from the scoreboard queue.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("active", int'(active), int'(exp_act[cur_k]));
      chk("urgent", int'(urgent), int'(exp_urg[cur_k]));
      chk("elapsed", int'(elapsed), exp_el[cur_k]);
      pv = {kill_p, skip_p, event_e, start_p};
      for (int i = 0; i < 4; i++) begin
        if (pv[i]) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected %s at k=%0d: got pulse, required none", kname(i), cur_k);
          end else begin
            e = q.pop_front();
            chk({"pulse kind (", kname(e.kind), ")"}, i, e.kind);
            chk({"pulse time (", kname(e.kind), ")"}, cur_k, e.at);
          end
        end
      end
    end
  end

  function automatic int sat(int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic reset_and_check();
    chk_en  = 1'b0;
    rst     = 1'b0;
    {start, skip_in, kill_in, stop, tick, inf_max} = '0;
    d_min   = '0;
    d_max   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", int'({start_p, event_e, skip_p, kill_p, urgent, active}), 0);
    chk("reset elapsed", int'(elapsed), 0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // skipmode: IDLE sees skip_in together with start (and kill0). Edge 0 is where start is sampled.
  task automatic run_trial(input int dmin, input int dmax, input bit inf, input bit skipmode,
                           input bit kill0, input int kill_e, input int stop_e, input int tmode);
    bit tk[L];
    int cum[L+1];
    int s, t_min, t_max, dmx, endk, ks, ss, lim;
    for (int k = 0; k < L; k++) begin
      case (tmode)
        0:       tk[k] = 1'b1;
        1:       tk[k] = (k % 2) == 1;
        2:       tk[k] = ($urandom % 2) == 0;
        default: tk[k] = ($urandom % 4) == 0;
      endcase
    end
    // cum[k]: time units accumulated before edge k, counting ticks from edge 1 on.
    s = 0;
    for (int k = 1; k <= L; k++) begin
      cum[k] = sat(s);
      if (k < L) s += int'(tk[k]);
    end
    cum[0] = 0;
    endk = L;
    if (skipmode) begin
      q.push_back('{kind: (kill0 ? KKill : KSkip), at: 0});
      endk = 0;
    end else begin
      t_min = L;
      for (int k = 1; k < L; k++) if (cum[k] >= dmin) begin t_min = k; break; end
      dmx = (dmax > dmin) ? dmax : dmin;
      if (kill_e > 0 && kill_e <= t_min) begin
        endk = kill_e;
        q.push_back('{kind: KKill, at: kill_e});
      end else if (t_min < L) begin
        q.push_back('{kind: KStart, at: t_min});
        t_max = L;
        if (!inf) for (int k = t_min + 1; k < L; k++) if (cum[k] >= dmx) begin t_max = k; break; end
        ks = (kill_e > t_min) ? kill_e : L;
        ss = (stop_e > t_min) ? stop_e : L;
        endk = (ks < ss) ? ks : ss;
        if (t_max < endk) endk = t_max;
        if (endk < L && endk == ks) q.push_back('{kind: KKill, at: endk});
        else if (endk < L && endk != ss) q.push_back('{kind: KEvent, at: endk});
      end
    end
    for (int k = 0; k < L; k++) begin
      exp_act[k] = !skipmode && (k < endk);
      exp_urg[k] = exp_act[k] && (dmin == dmax) && !inf;
      lim = (k < endk) ? k : endk;
      exp_el[k] = skipmode ? 0 : cum[lim + 1];
    end

    reset_and_check();
    for (int k = 0; k < L; k++) begin
      if (k == 0) begin
        start   = 1'b1;
        skip_in = skipmode;
        kill_in = skipmode && kill0;
        stop    = 1'b0;
        d_min   = W'(dmin);
        d_max   = W'(dmax);
        inf_max = inf;
      end else begin
        start   = ($urandom % 8) == 0;
        skip_in = ($urandom % 8) == 0;
        kill_in = (k == kill_e);
        stop    = (k == stop_e);
        d_min   = W'($urandom_range(0, 15));
        d_max   = W'($urandom_range(0, 15));
        inf_max = ($urandom % 2) == 0;
      end
      tick = tk[k];
      @(posedge clk);
      #1;
      cur_k  = k;
      chk_en = 1'b1;
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    chk("scoreboard drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    int dmin, dmax;
    n_chk  = 0;
    n_fail = 0;
    cur_k  = 0;
    chk_en = 1'b0;
    rst    = 1'b0;
    // Directed corner cases first.
    run_trial(3, 6, 0, 0, 0, 0, 0, 0);
    run_trial(2, 2, 0, 0, 0, 0, 0, 0);
    run_trial(1, 10, 0, 0, 0, 0, 5, 0);
    run_trial(0, 0, 0, 1, 0, 0, 0, 0);
    run_trial(0, 0, 0, 1, 1, 0, 0, 0);
    run_trial(3, 8, 0, 0, 0, 4, 0, 0);
    run_trial(0, 0, 1, 0, 0, 0, 0, 0);
    run_trial(4, 9, 0, 0, 0, 0, 0, 1);
    run_trial(7, 3, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < NRAND; t++) begin
      dmin = $urandom_range(0, 7);
      dmax = (($urandom % 4) == 0) ? dmin : $urandom_range(0, 15);
      run_trial(dmin, dmax, ($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 2) == 0,
                (($urandom % 4) == 0) ? $urandom_range(1, L - 1) : 0,
                (($urandom % 2) == 0) ? $urandom_range(1, 30) : 0, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of WAIT_MAX.
    reset_and_check();
    start   = 1'b1;
    tick    = 1'b1;
    d_min   = W'(0);
    d_max   = W'(10);
    inf_max = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cur_k = 4;
    chk("pre-reset active", int'(active), 1);
    chk("pre-reset elapsed", int'(elapsed), 3);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset outputs", int'({start_p, event_e, skip_p, kill_p, urgent, active}), 0);
    chk("async reset elapsed", int'(elapsed), 0);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
